// File: rtl/dac_settling_model.sv
// dac_settling_model: behavioural DAC with gain, saturation and first-order multi-cycle settling.
//    clk, reset (sync, active-high); start/code request a conversion while idle;
//    busy is high while settling, done pulses for one cycle when vout reaches its target,
//    and vout is the modelled output voltage. Define DAC_MSB_ERR_EN to model MSB capacitor
//    mismatch, which subtracts MSB_ERR from the target when the code MSB is set.
module dac_settling_model #(
   parameter int CODE_W       = 10,
   parameter int OUT_W        = 10,
   parameter int GAIN_NUM     = 6758,
   parameter int GAIN_SHIFT   = 14,
   parameter int SETTLE_SHIFT = 1,
   parameter int MAX_SETTLE   = 16,
   parameter int MSB_ERR      = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [CODE_W-1:0] code,
   output logic              busy,
   output logic              done,
   output logic [OUT_W-1:0]  vout
);
   localparam int PW = CODE_W + 16;
   localparam int CW = $clog2(MAX_SETTLE + 1);
   localparam logic signed [OUT_W:0] LIM = (OUT_W + 1)'(1 << SETTLE_SHIFT);
   typedef enum logic {IDLE, SETTLE} state_t;
   state_t            state_q, state_d;
   logic [OUT_W-1:0]  target_q, target_d, vout_q, vout_d, sat, tgt;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              busy_q, busy_d, done_q, done_d, fin;
   logic [PW-1:0]     prod, shifted;
   logic signed [OUT_W:0] diff, step;
   assign prod    = PW'(code) * PW'(GAIN_NUM);
   assign shifted = prod >> GAIN_SHIFT;
   assign sat     = (shifted > PW'({OUT_W{1'b1}})) ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
`ifdef DAC_MSB_ERR_EN
   assign tgt = !code[CODE_W-1] ? sat : (sat > OUT_W'(MSB_ERR)) ? sat - OUT_W'(MSB_ERR) : '0;
`else
   assign tgt = sat;
`endif
   assign diff = $signed({1'b0, target_q}) - $signed({1'b0, vout_q});
   // arithmetic shift floors toward -inf; with |diff| >= 2^SETTLE_SHIFT this never overshoots
   assign step = diff >>> SETTLE_SHIFT;
   assign fin  = (diff < LIM && diff > -LIM) || (int'(cnt_q) + 1 == MAX_SETTLE);
   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      cnt_d    = cnt_q;
      vout_d   = vout_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      if (state_q == IDLE) begin
         if (start) begin
            target_d = tgt;
            cnt_d    = '0;
            busy_d   = 1'b1;
            state_d  = SETTLE;
         end
      end else begin
         cnt_d   = cnt_q + CW'(1);
         vout_d  = fin ? target_q : OUT_W'($signed({1'b0, vout_q}) + step);
         state_d = fin ? IDLE : SETTLE;
         busy_d  = !fin;
         done_d  = fin;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         target_q <= '0;
         cnt_q    <= '0;
         vout_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         cnt_q    <= cnt_d;
         vout_q   <= vout_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end
   assign busy = busy_q;
   assign done = done_q;
   assign vout = vout_q;
endmodule
